// File: rtl/alu_pkg.sv
// ALU op-code constants and word-sequencer state encoding, shared by the ALU, the control unit and the sequencer.
// No logic; no latency or backpressure.
package alu_pkg;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_RSV1 = 3'b001;
  localparam logic [2:0] ALU_INC  = 3'b010;
  localparam logic [2:0] ALU_RSV3 = 3'b011;
  localparam logic [2:0] ALU_AND  = 3'b100;
  localparam logic [2:0] ALU_OR   = 3'b101;
  localparam logic [2:0] ALU_XOR  = 3'b110;
  localparam logic [2:0] ALU_ADC  = 3'b111;

  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_RUN,
    SEQ_DRAIN,
    SEQ_DONE,
    SEQ_ERR
  } seq_state_e;

  // ADC is internal to carry chaining and never accepted as a word-level op.
  function automatic logic op_supported(input logic [2:0] op);
    return !(op inside {ALU_RSV1, ALU_RSV3, ALU_ADC});
  endfunction

  function automatic logic op_is_arith(input logic [2:0] op);
    return (op == ALU_ADD) || (op == ALU_INC);
  endfunction

endpackage

// File: rtl/alu_word_sequencer.sv
// Drives the 8-bit ALU one byte per cycle (LSB first) to build a BYTES-wide result; done BYTES+2 cycles after accept, error done after 1.
// No backpressure: start is sampled only in IDLE and ignored while busy.
module alu_word_sequencer
  import alu_pkg::*;
#(
  parameter int BYTES = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [2:0]           op,
  input  logic [8*BYTES-1:0]   opa,
  input  logic [8*BYTES-1:0]   opb,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [8*BYTES-1:0]   result,
  output logic                 zero,
  output logic                 carry,
  output logic                 alu_enable,
  output logic [2:0]           alu_op,
  output logic [7:0]           alu_a,
  output logic [7:0]           alu_b,
  input  logic [7:0]           alu_out,
  input  logic                 alu_carry
);

  localparam int W  = 8 * BYTES;
  localparam int IW = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(BYTES - 1);

  seq_state_e    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] prev_idx;
  logic [2:0]    op_q, op_d;
  logic [W-1:0]  opa_q, opa_d;
  logic [W-1:0]  opb_q, opb_d;
  logic [W-1:0]  result_q, result_d;
  logic          zero_q, zero_d;
  logic          carry_q, carry_d;

  assign prev_idx = idx_q - 1'b1;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    op_d       = op_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    result_d   = result_q;
    zero_d     = zero_q;
    carry_d    = carry_q;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    alu_enable = 1'b0;
    alu_op     = '0;
    alu_a      = '0;
    alu_b      = '0;

    case (state_q)
      SEQ_IDLE: begin
        if (start) begin
          if (op_supported(op)) begin
            op_d    = op;
            opa_d   = opa;
            opb_d   = opb;
            idx_d   = '0;
            state_d = SEQ_RUN;
          end else begin
            state_d = SEQ_ERR;
          end
        end
      end
      SEQ_RUN: begin
        busy       = 1'b1;
        alu_enable = 1'b1;
        alu_op     = op_q;
        alu_a      = opa_q[{idx_q, 3'b000} +: 8];
        alu_b      = (op_q == ALU_INC) ? 8'h00 : opb_q[{idx_q, 3'b000} +: 8];
        // Byte 0 uses plain ADD/INC so a stale ALU carry never enters the word.
        if (idx_q != '0) begin
          if (op_is_arith(op_q)) begin
            alu_op = ALU_ADC;
          end
          result_d[{prev_idx, 3'b000} +: 8] = alu_out;
        end
        if (idx_q == LAST_IDX) begin
          state_d = SEQ_DRAIN;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      SEQ_DRAIN: begin
        busy              = 1'b1;
        result_d[W-1 -: 8] = alu_out;
        carry_d           = op_is_arith(op_q) ? alu_carry : 1'b0;
        zero_d            = ~|result_d;
        state_d           = SEQ_DONE;
      end
      SEQ_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = SEQ_IDLE;
      end
      SEQ_ERR: begin
        busy    = 1'b1;
        done    = 1'b1;
        err     = 1'b1;
        state_d = SEQ_IDLE;
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= SEQ_IDLE;
      idx_q    <= '0;
      op_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      op_q     <= op_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
    end
  end

  assign result = result_q;
  assign zero   = zero_q;
  assign carry  = carry_q;

endmodule

// File: tb/tb_alu_word_sequencer.sv
// Bench for alu_word_sequencer (BYTES=2) with a registered 8-bit ALU model and a result scoreboard.
module tb_alu_word_sequencer;
  import alu_pkg::*;

  localparam int BYTES = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [15:0] opa = '0;
  logic [15:0] opb = '0;
  logic        busy, done, err, zero, carry, alu_enable;
  logic [15:0] result;
  logic [2:0]  alu_op;
  logic [7:0]  alu_a, alu_b;
  logic [7:0]  alu_out = '0;
  logic        alu_carry = 1'b0;

  always #5 clk = ~clk;

  alu_word_sequencer #(.BYTES(BYTES)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .opa(opa), .opb(opb),
    .busy(busy), .done(done), .err(err), .result(result), .zero(zero), .carry(carry),
    .alu_enable(alu_enable), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_carry(alu_carry)
  );

  // ALU: registered result and carry; logic ops leave the carry flag untouched.
  always @(posedge clk) begin
    if (alu_enable) begin
      case (alu_op)
        ALU_ADD: {alu_carry, alu_out} <= {1'b0, alu_a} + {1'b0, alu_b};
        ALU_ADC: {alu_carry, alu_out} <= {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_carry};
        ALU_INC: {alu_carry, alu_out} <= {1'b0, alu_a} + 9'd1;
        ALU_AND: alu_out <= alu_a & alu_b;
        ALU_OR:  alu_out <= alu_a | alu_b;
        ALU_XOR: alu_out <= alu_a ^ alu_b;
        default: alu_out <= 8'h00;
      endcase
    end
  end

  typedef struct {
    logic [15:0] res;
    logic        z;
    logic        c;
    logic        e;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          passed = 0;
  int          fails = 0;
  logic [15:0] m_res = '0;
  logic        m_z = 1'b0;
  logic        m_c = 1'b0;
  logic [2:0]  op_c1, op_c2;
  logic [7:0]  b_c2;
  int          drive_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
    exp_t        e;
    logic [16:0] s;
    e.e = 1'b0;
    case (o)
      ALU_ADD: s = {1'b0, a} + {1'b0, b};
      ALU_INC: s = {1'b0, a} + 17'd1;
      ALU_AND: s = {1'b0, a & b};
      ALU_OR:  s = {1'b0, a | b};
      ALU_XOR: s = {1'b0, a ^ b};
      default: begin
        e.e = 1'b1;
        s   = {m_c, m_res};
      end
    endcase
    e.res = s[15:0];
    e.c   = s[16];
    e.z   = e.e ? m_z : (s[15:0] == 16'h0000);
    m_res = e.res;
    m_c   = e.c;
    m_z   = e.z;
    sb.push_back(e);
  endtask

  // Steps cycle by cycle until done (bounded), tracing the ALU-side outputs, then scores the result.
  task automatic collect(input int rel_at, input bit poke, input int exp_done, input int exp_en);
    int   cyc = 0;
    int   en_cnt = 0;
    int   done_cyc = -1;
    bit   got = 1'b0;
    exp_t e;
    op_c1 = 'x;
    op_c2 = 'x;
    b_c2  = 'x;
    while (!got && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == rel_at) start = 1'b0;
      if (poke && cyc == 2) begin
        start = 1'b1;
        op    = ALU_XOR;
      end
      if (poke && cyc == 3) start = 1'b0;
      if (alu_enable) begin
        en_cnt++;
        if (cyc == 1) op_c1 = alu_op;
        if (cyc == 2) begin
          op_c2 = alu_op;
          b_c2  = alu_b;
        end
      end else if ({alu_op, alu_a, alu_b} != 19'h0) begin
        drive_bad++;
      end
      if (done) begin
        got      = 1'b1;
        done_cyc = cyc;
      end
    end
    chk("done_seen", got, 1);
    chk("done_cycle", done_cyc, exp_done);
    chk("enable_cycles", en_cnt, exp_en);
    if (got && sb.size() > 0) begin
      e = sb.pop_front();
      chk("result", result, e.res);
      chk("zero", zero, e.z);
      chk("carry", carry, e.c);
      chk("err", err, e.e);
    end
  endtask

  task automatic run(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                     input bit poke, input int exp_done, input int exp_en);
    push_exp(o, a, b);
    op    = o;
    opa   = a;
    opb   = b;
    start = 1'b1;
    collect(1, poke, exp_done, exp_en);
    @(posedge clk);
    #1;
    chk("idle_after", {busy, done, err}, 3'b000);
  endtask

  initial begin
    #3;
    chk("reset_outputs", {busy, done, err, result, zero, carry, alu_enable, alu_op, alu_a, alu_b}, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    run(ALU_ADD, 16'hFFFF, 16'h0001, 1'b0, 4, 2);
    run(ALU_ADD, 16'h12FF, 16'h0001, 1'b0, 4, 2);
    chk("add_op_byte0", op_c1, ALU_ADD);
    chk("add_op_byte1", op_c2, ALU_ADC);
    run(ALU_INC, 16'hFFFF, 16'h1234, 1'b0, 4, 2);
    run(ALU_INC, 16'h00FF, 16'hBEEF, 1'b0, 4, 2);
    chk("inc_op_byte0", op_c1, ALU_INC);
    chk("inc_op_byte1", op_c2, ALU_ADC);
    chk("inc_b_byte1", b_c2, 8'h00);
    run(ALU_RSV1, 16'h5555, 16'h5555, 1'b0, 1, 0);
    run(ALU_ADD, 16'hFFFF, 16'h0001, 1'b0, 4, 2);
    run(ALU_XOR, 16'hA5A5, 16'hA5A5, 1'b0, 4, 2);
    chk("xor_op_byte0", op_c1, ALU_XOR);
    chk("xor_op_byte1", op_c2, ALU_XOR);
    run(ALU_OR, 16'h1200, 16'h0034, 1'b1, 4, 2);
    run(ALU_AND, 16'hF0F0, 16'h3C3C, 1'b0, 4, 2);

    // Held start: back-to-back operations every BYTES+3 cycles.
    push_exp(ALU_ADD, 16'h0001, 16'h0001);
    push_exp(ALU_ADD, 16'h0001, 16'h0001);
    op    = ALU_ADD;
    opa   = 16'h0001;
    opb   = 16'h0001;
    start = 1'b1;
    collect(0, 1'b0, 4, 2);
    collect(2, 1'b0, 5, 2);
    @(posedge clk);
    #1;
    chk("idle_after_held", {busy, done, err}, 3'b000);

    // Abort in cycle 2 of an ADD.
    op    = ALU_ADD;
    opa   = 16'h1111;
    opb   = 16'h2222;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("enable_before_abort", alu_enable, 1);
    reset_n = 1'b0;
    #1;
    chk("reset_abort", {busy, done, err, result, zero, carry, alu_enable, alu_op, alu_a, alu_b}, 0);
    m_res = '0;
    m_z   = 1'b0;
    m_c   = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    run(ALU_ADD, 16'h0102, 16'h0304, 1'b0, 4, 2);

    chk("idle_drive_zero", drive_bad, 0);
    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
